// File: rtl/mem_io_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// slc3_mem_pkg
// Shared types and constants for the SLC-3 memory/IO access controller.
//   mem_state_t     : controller state encoding (IDLE, ACCESS, DONE)
//   IO_ADDR_DEFAULT : default memory-mapped IO address (switches / hex display)
//   WAIT_W          : width of the SRAM wait-state counter
// -----------------------------------------------------------------------------
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam int          WAIT_W          = 4;

endpackage

// File: rtl/mem_io_ctrl_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Loadable down-counter that times the SRAM access dwell. It saturates at
// zero so a stray enable after expiry cannot wrap it.
// Ports:
//   Clk      in   clock, rising edge
//   Reset    in   synchronous, active-low reset (count -> 0)
//   load     in   load load_val (takes priority over en)
//   load_val in   value to load
//   en       in   decrement enable
//   zero     out  count is zero
// -----------------------------------------------------------------------------
module mem_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_io_ctrl.sv
// -----------------------------------------------------------------------------
// mem_io_ctrl
// Memory/IO access controller for the SLC-3 datapath. Requests from the
// control FSM are accepted only in IDLE. Accesses to IO_ADDR complete in one
// cycle against the switches (read) or hex register (write); all other
// addresses drive the external SRAM for WAIT_CYCLES cycles. R pulses for one
// cycle when the access completes.
// Optional build macro: MEM_IO_PROTO_ERR_EN adds a sticky 'err' output that
// flags simultaneous read/write requests and requests outside IDLE.
// Ports:
//   Clk, Reset          clock (rising edge), synchronous active-low reset
//   MAR, MDR            address / write data from datapath
//   req_rd, req_wr      read / write request (write wins if both set)
//   MDR_In              read data back to datapath
//   R                   one-cycle completion pulse
//   mem_addr, mem_wdata SRAM address / write data (registered)
//   mem_rdata           SRAM read data
//   mem_ce_n/oe_n/we_n  SRAM strobes, active low (registered)
//   SW                  board switches, read at IO_ADDR
//   hex_out             hex display register, written at IO_ADDR
//   err                 (MEM_IO_PROTO_ERR_EN only) sticky protocol error
// -----------------------------------------------------------------------------
module mem_io_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        req_rd,
    input  logic        req_wr,
    output logic [15:0] MDR_In,
    output logic        R,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    input  logic [15:0] SW,
    output logic [15:0] hex_out
`ifdef MEM_IO_PROTO_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(WAIT_CYCLES - 1);

    mem_state_t state, next_state;

    logic dir_wr;       // latched direction of the access in flight
    logic accept;
    logic is_io;
    logic wr_next;      // direction that applies in the next state
    logic cnt_zero;

    logic r_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;

    assign accept = (state == IDLE) && (req_rd || req_wr);
    assign is_io  = (MAR == IO_ADDR);

    mem_wait_counter #(
        .WIDTH (WAIT_W)
    ) u_wait (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (accept && !is_io),
        .load_val (LOAD_VAL),
        .en       (state == ACCESS),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = is_io ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: strobes and R are computed from the next state and
    // registered, so they line up with the state register and clear on the
    // same edge that a reset aborts an access.
    always_comb begin
        wr_next  = (state == IDLE) ? req_wr : dir_wr;
        r_nxt    = (next_state == DONE);
        ce_n_nxt = !(next_state == ACCESS);
        oe_n_nxt = !((next_state == ACCESS) && !wr_next);
        we_n_nxt = !((next_state == ACCESS) && wr_next);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            R        <= 1'b0;
            mem_ce_n <= 1'b1;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
        end else begin
            R        <= r_nxt;
            mem_ce_n <= ce_n_nxt;
            mem_oe_n <= oe_n_nxt;
            mem_we_n <= we_n_nxt;
        end
    end

    // Address/data capture, IO registers and read-data return
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            dir_wr    <= 1'b0;
            hex_out   <= '0;
            MDR_In    <= '0;
        end else begin
            if (accept) begin
                mem_addr  <= MAR;
                mem_wdata <= MDR;
                dir_wr    <= req_wr;
                if (is_io) begin
                    if (req_wr) begin
                        hex_out <= MDR;
                    end else begin
                        MDR_In <= SW;
                    end
                end
            end
            if ((state == ACCESS) && cnt_zero && !dir_wr) begin
                MDR_In <= mem_rdata;
            end
        end
    end

`ifdef MEM_IO_PROTO_ERR_EN
    // Sticky: only reset clears it
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            err <= 1'b0;
        end else if (((state == IDLE) && req_rd && req_wr) ||
                     ((state != IDLE) && (req_rd || req_wr))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_io_ctrl
// Scoreboard bench for mem_io_ctrl (WAIT_CYCLES=2, IO_ADDR=16'hFFFF).
// Expected MDR_In / hex_out are pushed when a request is driven and popped
// when R is observed. Compile with MEM_IO_PROTO_ERR_EN to also cover err.
// -----------------------------------------------------------------------------
module tb_mem_io_ctrl;

    localparam int          WAIT = 2;
    localparam logic [15:0] IOA  = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] MAR, MDR, mem_rdata, SW;
    logic        req_rd, req_wr;
    logic [15:0] MDR_In, mem_addr, mem_wdata, hex_out;
    logic        R, mem_ce_n, mem_oe_n, mem_we_n;
`ifdef MEM_IO_PROTO_ERR_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] sb_mdr[$];
    logic [15:0] sb_hex[$];
    logic [15:0] m_mdr = 16'h0;
    logic [15:0] m_hex = 16'h0;

    mem_io_ctrl #(
        .WAIT_CYCLES (WAIT),
        .IO_ADDR     (IOA)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .MAR       (MAR),
        .MDR       (MDR),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .MDR_In    (MDR_In),
        .R         (R),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ce_n  (mem_ce_n),
        .mem_oe_n  (mem_oe_n),
        .mem_we_n  (mem_we_n),
        .SW        (SW),
        .hex_out   (hex_out)
`ifdef MEM_IO_PROTO_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, then watch strobes until R (bounded).
    // poke: drive a stray read with a different MAR during ACCESS.
    task automatic do_req(input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] data,
                          input int exp_lat, input int exp_ce,
                          input int exp_oe, input int exp_we, input bit poke);
        int cyc, ce, oe, we;
        logic [15:0] em, eh;
        @(negedge Clk);
        check_eq("idle_r_low", R, 1'b0);
        MAR = addr; MDR = data; req_rd = rd; req_wr = wr;
        if (wr) begin
            if (addr == IOA) m_hex = data;
        end else begin
            m_mdr = (addr == IOA) ? SW : mem_rdata;
        end
        sb_mdr.push_back(m_mdr);
        sb_hex.push_back(m_hex);
        @(negedge Clk);
        req_rd = 1'b0; req_wr = 1'b0;
        cyc = 1; ce = 0; oe = 0; we = 0;
        while (R !== 1'b1 && cyc < 20) begin
            if (mem_ce_n === 1'b0) ce++;
            if (mem_oe_n === 1'b0) oe++;
            if (mem_we_n === 1'b0) we++;
            if (poke && cyc == 1) begin
                req_rd = 1'b1; MAR = 16'h0BAD; MDR = 16'hDEAD;
            end else if (poke) begin
                req_rd = 1'b0;
            end
            @(negedge Clk);
            cyc++;
        end
        req_rd = 1'b0;
        if (R !== 1'b1) begin
            check_eq("r_timeout", 32'd0, 32'd1);
            void'(sb_mdr.pop_front());
            void'(sb_hex.pop_front());
        end else begin
            check_eq("latency", cyc, exp_lat);
            check_eq("ce_cycles", ce, exp_ce);
            check_eq("oe_cycles", oe, exp_oe);
            check_eq("we_cycles", we, exp_we);
            check_eq("done_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
            check_eq("mem_addr", mem_addr, addr);
            if (wr) check_eq("mem_wdata", mem_wdata, data);
            em = sb_mdr.pop_front();
            eh = sb_hex.pop_front();
            check_eq("mdr_in", MDR_In, em);
            check_eq("hex_out", hex_out, eh);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; MAR = 16'h0; MDR = 16'h0; req_rd = 1'b1; req_wr = 1'b0;
        mem_rdata = 16'h0; SW = 16'h0;

        // Reset held with a request pending
        repeat (2) @(negedge Clk);
        check_eq("rst_r", R, 1'b0);
        check_eq("rst_mdr_in", MDR_In, 16'h0);
        check_eq("rst_hex", hex_out, 16'h0);
        check_eq("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
        check_eq("rst_addr", mem_addr, 16'h0);
`ifdef MEM_IO_PROTO_ERR_EN
        check_eq("rst_err", err, 1'b0);
`endif
        req_rd = 1'b0;
        Reset = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check_eq("post_rst_no_r", R, 1'b0);
        end

        // SRAM read
        mem_rdata = 16'hBEEF;
        do_req(1'b1, 1'b0, 16'h0040, 16'h0000, WAIT + 1, WAIT, WAIT, 0, 1'b0);
        // SRAM write: MDR_In must keep BEEF
        mem_rdata = 16'h7777;
        do_req(1'b0, 1'b1, 16'h0100, 16'h1234, WAIT + 1, WAIT, 0, WAIT, 1'b0);
        // IO write, then IO read
        do_req(1'b0, 1'b1, IOA, 16'h00A5, 1, 0, 0, 0, 1'b0);
        SW = 16'h3C3C;
        do_req(1'b1, 1'b0, IOA, 16'h0000, 1, 0, 0, 0, 1'b0);
        // IO write again (hex update, MDR_In held)
        do_req(1'b0, 1'b1, IOA, 16'h5A0F, 1, 0, 0, 0, 1'b0);
`ifdef MEM_IO_PROTO_ERR_EN
        check_eq("err_clean", err, 1'b0);
`endif
        // Both requests together: write wins
        mem_rdata = 16'h1111;
        do_req(1'b1, 1'b1, 16'h0200, 16'hCAFE, WAIT + 1, WAIT, 0, WAIT, 1'b0);
`ifdef MEM_IO_PROTO_ERR_EN
        check_eq("err_both", err, 1'b1);
`endif
        // Stray request during ACCESS is ignored
        mem_rdata = 16'h5A5A;
        do_req(1'b1, 1'b0, 16'h0300, 16'h0000, WAIT + 1, WAIT, WAIT, 0, 1'b1);
        repeat (3) begin
            @(negedge Clk);
            check_eq("stray_no_r", R, 1'b0);
        end
        check_eq("stray_addr", mem_addr, 16'h0300);
`ifdef MEM_IO_PROTO_ERR_EN
        check_eq("err_sticky", err, 1'b1);
`endif

        // Reset during the second ACCESS cycle
        mem_rdata = 16'h9999;
        @(negedge Clk);
        MAR = 16'h0400; req_rd = 1'b1;
        @(negedge Clk);
        req_rd = 1'b0;
        check_eq("acc1_ce", mem_ce_n, 1'b0);
        @(negedge Clk);
        check_eq("acc2_ce", mem_ce_n, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("abort_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
        check_eq("abort_r", R, 1'b0);
        check_eq("abort_mdr_in", MDR_In, 16'h0);
        check_eq("abort_hex", hex_out, 16'h0);
`ifdef MEM_IO_PROTO_ERR_EN
        check_eq("err_cleared", err, 1'b0);
`endif
        Reset = 1'b1;
        m_mdr = 16'h0; m_hex = 16'h0;
        repeat (4) begin
            @(negedge Clk);
            check_eq("abort_no_r", R, 1'b0);
        end

        // Normal operation resumes after the aborted access
        mem_rdata = 16'h0F0F;
        do_req(1'b1, 1'b0, 16'h0500, 16'h0000, WAIT + 1, WAIT, WAIT, 0, 1'b0);

        check_eq("sb_empty", sb_mdr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_io_ctrl.md
Name: mem_io_ctrl

Overview:
- Memory/IO access controller on the downstream side of the SLC-3 datapath.
- Consumes MAR and MDR plus read/write requests from the control FSM.
- Drives an external SRAM with a fixed wait-state count and memory-maps the switch input and hex-display output at IO_ADDR.
- Returns read data on MDR_In, which the datapath loads into MDR when MIO_EN is set, and pulses R for one cycle on completion.

Parameters:
- WAIT_CYCLES, 2: SRAM access cycles per transaction; legal range 1..15.
- IO_ADDR, 16'hFFFF: memory-mapped IO address (SW read / hex write).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- MAR  in  16  access address from datapath.
- MDR  in  16  write data from datapath.
- req_rd  in  1  read request from control FSM.
- req_wr  in  1  write request from control FSM.
- MDR_In  out  16  read data to datapath.
- R  out  1  one-cycle completion pulse.
- mem_addr  out  16  SRAM address.
- mem_wdata  out  16  SRAM write data.
- mem_rdata  in  16  SRAM read data.
- mem_ce_n  out  1  SRAM chip enable, active low.
- mem_oe_n  out  1  SRAM output enable, active low.
- mem_we_n  out  1  SRAM write enable, active low.
- SW  in  16  board switches, read at IO_ADDR.
- hex_out  out  16  hex-display register, written at IO_ADDR.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - State goes to IDLE.
  - R=0, MDR_In=0, hex_out=0, mem_addr=0, mem_wdata=0, mem_ce_n=mem_oe_n=mem_we_n=1, wait counter=0.
  - Reset mid-access aborts the access: no R pulse, and SRAM strobes deassert on the same edge.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in IDLE; requests in ACCESS or DONE are ignored.
  - On req_wr or req_rd, latch MAR into mem_addr, MDR into mem_wdata, and the direction into an internal flag.
  - If req_rd and req_wr are both high, the write wins.
  - If MAR==IO_ADDR, go straight to DONE:
    - write: hex_out<=MDR;
    - read: MDR_In<=SW;
    - SRAM strobes stay inactive.
  - Otherwise go to ACCESS with counter=WAIT_CYCLES-1.
- ACCESS:
  - mem_ce_n=0 for every ACCESS cycle.
  - Read: mem_oe_n=0, mem_we_n=1.
  - Write: mem_we_n=0, mem_oe_n=1.
  - The counter decrements each cycle.
  - When counter==0: if read, MDR_In<=mem_rdata; go to DONE.
- DONE: R=1 for exactly this cycle; strobes inactive; next state IDLE.
- Latency from the request-sampling edge to R high:
  - SRAM access: WAIT_CYCLES+1 cycles.
  - IO access: 1 cycle.
  - A back-to-back request is sampled at the earliest one cycle after DONE, in IDLE.
- Hold rules:
  - MDR_In holds its last read value until the next read completes; writes never change it.
  - hex_out holds until the next IO write.
- Address/data are registered, so MAR/MDR changing during ACCESS has no effect.
- R is a registered output driven from the state.

Optional Feature:
- Macro: MEM_IO_PROTO_ERR_EN.
- With the macro defined:
  - Adds output err (1 bit), a sticky flag.
  - err sets when req_rd and req_wr are high together in IDLE.
  - err sets when any request is high in ACCESS or DONE.
  - err clears only on reset.
  - Reset value 0.
- Without the macro: the err port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package slc3_mem_pkg:
  - state enum mem_state_t {IDLE, ACCESS, DONE};
  - IO_ADDR default constant;
  - WAIT_W=4 counter width.
- One sub-module, mem_wait_counter:
  - loadable down-counter with load value, enable and zero flag;
  - parameterized by width;
  - used for the ACCESS dwell.

Test Plan:
- Reset sequence: hold Reset=0 for 2 cycles while req_rd=1 -> R=0, MDR_In=0, hex_out=0, all strobes high; release -> IDLE, no spurious R.
- SRAM read, WAIT_CYCLES=2: MAR=16'h0040, req_rd=1 for 1 cycle, mem_rdata=16'hBEEF -> mem_ce_n=mem_oe_n=0 for exactly 2 cycles, R high on cycle 3, MDR_In=16'hBEEF.
- SRAM write: MAR=16'h0100, MDR=16'h1234, req_wr -> mem_addr=16'h0100, mem_wdata=16'h1234, mem_we_n=0 for 2 cycles; R on cycle 3; MDR_In unchanged.
- IO path:
  - write MAR=16'hFFFF, MDR=16'h00A5 -> hex_out=16'h00A5, R after 1 cycle, strobes never asserted;
  - read with SW=16'h3C3C -> MDR_In=16'h3C3C, R after 1 cycle.
- Simultaneous events:
  - req_rd and req_wr together -> a write is performed;
  - a new request during ACCESS is ignored;
  - with MEM_IO_PROTO_ERR_EN, err=1 and stays set until reset.
- Reset mid-ACCESS: assert Reset=0 at the second ACCESS cycle -> strobes high next edge, R never pulses, MDR_In=0.
